dcache_ctrl: RTL and testbench

- Controller that sequences the 2-way set-associative, write-back, write-allocate data cache SRAM (16 sets, 256-bit lines) between the CPU load/store port and the off-chip data memory.
- Handles lookup, LRU victim selection, dirty-line write-back, line refill and word merge on store.
- CPU is stalled for the full duration of a miss.

---
 rtl/dcache_pkg.sv | 49 ++++
 rtl/dcache_lru.sv | 26 ++
 rtl/dcache_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types, field positions and address helpers for the 2-way data cache controller.
package dcache_pkg;

    localparam int TAG_W     = 23;
    localparam int IDX_W     = 4;
    localparam int LINE_W    = 256;
    localparam int SETS      = 16;
    localparam int VALID_BIT = 24;
    localparam int DIRTY_BIT = 23;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        FETCH  = 2'd2,
        REFILL = 2'd3
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
        return TAG_W'(addr >> 9);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
        return IDX_W'(addr >> 5);
    endfunction

    function automatic logic [2:0] addr_word(input logic [31:0] addr);
        return 3'(addr >> 2);
    endfunction

    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                              input logic [IDX_W-1:0] idx);
        return {tag, idx, 5'b0};
    endfunction

    function automatic logic [31:0] get_word(input logic [LINE_W-1:0] line,
                                             input logic [2:0] word);
        return line[{word, 5'b0} +: 32];
    endfunction

    function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line,
                                                   input logic [2:0] word,
                                                   input logic [31:0] data);
        logic [LINE_W-1:0] merged;
        merged = line;
        merged[{word, 5'b0} +: 32] = data;
        return merged;
    endfunction

endpackage

// File: rtl/dcache_lru.sv
// Per-set LRU bit array: each bit names the way to evict next in its set.
module dcache_lru
    import dcache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_set,
    input  logic             used_way,
    input  logic [IDX_W-1:0] rd_set,
    output logic             victim
);

    logic [SETS-1:0] lru;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lru <= '0;
        end else if (upd_en) begin
            lru[upd_set] <= ~used_way;
        end
    end

    assign victim = lru[rd_set];

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate controller for a 2-way, 16-set data cache.
// Optional DCACHE_STATS_EN adds saturating hit/miss counters.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cpu_req_i,
    input  logic                cpu_write_i,
    input  logic [31:0]         cpu_addr_i,
    input  logic [31:0]         cpu_data_i,
    output logic [31:0]         cpu_data_o,
    output logic                cpu_stall_o,
    output logic                sram_enable_o,
    output logic                sram_write_o,
    output logic                sram_way_o,
    output logic [IDX_W-1:0]    sram_addr_o,
    output logic [TAG_W+1:0]    sram_tag_o,
    output logic [LINE_W-1:0]   sram_data_o,
    input  logic [TAG_W+1:0]    sram_tag_i,
    input  logic [LINE_W-1:0]   sram_data_i,
    input  logic                sram_hit_i,
    output logic                mem_enable_o,
    output logic                mem_write_o,
    output logic [31:0]         mem_addr_o,
    output logic [LINE_W-1:0]   mem_data_o,
    input  logic [LINE_W-1:0]   mem_data_i,
    input  logic                mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]         stat_hit_o,
    output logic [31:0]         stat_miss_o
`endif
);

    state_t             state;
    logic [TAG_W-1:0]   tag_q;
    logic [IDX_W-1:0]   set_q;
    logic               way_q;
    logic [LINE_W-1:0]  wb_line_q;
    logic [LINE_W-1:0]  fill_line_q;

    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_set;
    logic [2:0]         req_word;
    logic               lookup;
    logic               hit;
    logic               miss;
    logic               hit_way;
    logic               victim;
    logic               victim_dirty;

    // Tag shadow lets the controller name the hit way; its valid bits are
    // assumed to clear together with the tag SRAM's on reset.
    logic [TAG_W-1:0]   shadow_tag [2][SETS];
    logic [SETS-1:0]    shadow_vld [2];

    assign req_tag      = addr_tag(cpu_addr_i);
    assign req_set      = addr_idx(cpu_addr_i);
    assign req_word     = addr_word(cpu_addr_i);
    assign lookup       = (state == IDLE) && cpu_req_i;
    assign hit          = lookup && sram_hit_i;
    assign miss         = lookup && !sram_hit_i;
    assign hit_way      = shadow_vld[1][req_set] && (shadow_tag[1][req_set] == req_tag);
    assign victim_dirty = sram_tag_i[VALID_BIT] && sram_tag_i[DIRTY_BIT];

    dcache_lru u_lru (
        .clk      (clk_i),
        .rst      (rst_i),
        .upd_en   (hit || (state == REFILL)),
        .upd_set  ((state == REFILL) ? set_q : req_set),
        .used_way ((state == REFILL) ? way_q : hit_way),
        .rd_set   (req_set),
        .victim   (victim)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        state        <= victim_dirty ? WB : FETCH;
                        mem_enable_o <= 1'b1;
                        mem_write_o  <= victim_dirty;
                        mem_addr_o   <= victim_dirty ? line_addr(sram_tag_i[TAG_W-1:0], req_set)
                                                     : line_addr(req_tag, req_set);
                    end
                end
                WB: begin
                    if (mem_ack_i) begin
                        state       <= FETCH;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= line_addr(tag_q, set_q);
                    end
                end
                FETCH: begin
                    if (mem_ack_i) begin
                        state        <= REFILL;
                        mem_enable_o <= 1'b0;
                        mem_addr_o   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Miss context is captured once at detect so CPU-side changes cannot disturb it.
    always_ff @(posedge clk_i) begin
        if (miss) begin
            tag_q     <= req_tag;
            set_q     <= req_set;
            way_q     <= victim;
            wb_line_q <= sram_data_i;
        end
        if ((state == FETCH) && mem_ack_i) begin
            fill_line_q <= mem_data_i;
        end
        if (state == REFILL) begin
            shadow_tag[way_q][set_q] <= tag_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_vld[0] <= '0;
            shadow_vld[1] <= '0;
        end else if (state == REFILL) begin
            shadow_vld[way_q][set_q] <= 1'b1;
        end
    end

    assign sram_enable_o = (state != IDLE) || cpu_req_i;
    assign sram_addr_o   = (state == IDLE) ? (cpu_req_i ? req_set : '0) : set_q;
    assign sram_tag_o    = (state == IDLE) ? (cpu_req_i ? {1'b1, cpu_write_i, req_tag} : '0)
                                           : {1'b1, 1'b0, tag_q};
    assign sram_way_o    = (state == IDLE) ? (cpu_req_i && (sram_hit_i ? hit_way : victim))
                                           : way_q;
    assign mem_data_o    = mem_write_o ? wb_line_q : '0;

    always_comb begin
        cpu_stall_o  = 1'b0;
        cpu_data_o   = '0;
        sram_write_o = 1'b0;
        sram_data_o  = '0;
        if (state == IDLE) begin
            if (cpu_req_i) begin
                if (!sram_hit_i) begin
                    cpu_stall_o = 1'b1;
                end else if (cpu_write_i) begin
                    sram_write_o = 1'b1;
                    sram_data_o  = put_word(sram_data_i, req_word, cpu_data_i);
                end else begin
                    cpu_data_o = get_word(sram_data_i, req_word);
                end
            end
        end else begin
            cpu_stall_o = 1'b1;
            if (state == REFILL) begin
                sram_write_o = 1'b1;
                sram_data_o  = fill_line_q;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic relookup_q;

    // The hit that completes a refilled miss is not a first-try hit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_hit_o  <= '0;
            stat_miss_o <= '0;
            relookup_q  <= 1'b0;
        end else begin
            if (state == REFILL) begin
                relookup_q <= 1'b1;
            end else if (hit) begin
                relookup_q <= 1'b0;
            end
            if (hit && !relookup_q && (stat_hit_o != '1)) begin
                stat_hit_o <= stat_hit_o + 32'd1;
            end
            if (miss && (stat_miss_o != '1)) begin
                stat_miss_o <= stat_miss_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a behavioural 2-way SRAM and a hand-driven memory port.
module tb_dcache_ctrl;

    logic         clk;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_write_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         sram_enable_o;
    logic         sram_write_o;
    logic         sram_way_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_hit_i;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
    logic [31:0]  stat_hit_o;
    logic [31:0]  stat_miss_o;
`endif

    int tests  = 0;
    int failed = 0;

    dcache_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .cpu_req_i     (cpu_req_i),
        .cpu_write_i   (cpu_write_i),
        .cpu_addr_i    (cpu_addr_i),
        .cpu_data_i    (cpu_data_i),
        .cpu_data_o    (cpu_data_o),
        .cpu_stall_o   (cpu_stall_o),
        .sram_enable_o (sram_enable_o),
        .sram_write_o  (sram_write_o),
        .sram_way_o    (sram_way_o),
        .sram_addr_o   (sram_addr_o),
        .sram_tag_o    (sram_tag_o),
        .sram_data_o   (sram_data_o),
        .sram_tag_i    (sram_tag_i),
        .sram_data_i   (sram_data_i),
        .sram_hit_i    (sram_hit_i),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i)
`ifdef DCACHE_STATS_EN
        ,
        .stat_hit_o    (stat_hit_o),
        .stat_miss_o   (stat_miss_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural cache SRAM: combinational hit/read, write on clock edge.
    logic [24:0]  m_tag  [2][16];
    logic [255:0] m_data [2][16];
    logic         model_clr;
    logic         h0, h1, rd_way;

    assign h0 = m_tag[0][sram_addr_o][24] && (m_tag[0][sram_addr_o][22:0] == sram_tag_o[22:0]);
    assign h1 = m_tag[1][sram_addr_o][24] && (m_tag[1][sram_addr_o][22:0] == sram_tag_o[22:0]);
    assign sram_hit_i  = sram_enable_o && (h0 || h1);
    assign rd_way      = h1 ? 1'b1 : (h0 ? 1'b0 : sram_way_o);
    assign sram_tag_i  = m_tag[rd_way][sram_addr_o];
    assign sram_data_i = m_data[rd_way][sram_addr_o];

    always @(posedge clk) begin
        if (model_clr) begin
            for (int w = 0; w < 2; w++) begin
                for (int s = 0; s < 16; s++) begin
                    m_tag[w][s]  <= '0;
                    m_data[w][s] <= '0;
                end
            end
        end else if (sram_enable_o && sram_write_o) begin
            m_tag[sram_way_o][sram_addr_o]  <= sram_tag_o;
            m_data[sram_way_o][sram_addr_o] <= sram_data_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    function automatic logic [255:0] mkline(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    // Waits for a memory request, checks it, holds it for lat cycles, then acks.
    task automatic mem_serve(input string nm, input logic ew, input logic [31:0] ea,
                             input logic [255:0] ed, input logic [255:0] rd, input int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!mem_enable_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk({nm, " mem_enable"}, mem_enable_o, 1'b1);
        chk({nm, " mem_write"}, mem_write_o, ew);
        chk({nm, " mem_addr"}, mem_addr_o, ea);
        chk({nm, " stall"}, cpu_stall_o, 1'b1);
        if (ew) chk({nm, " mem_data"}, mem_data_o, ed);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            #1;
            chk({nm, " addr held"}, mem_addr_o, ea);
        end
        @(negedge clk);
        mem_ack_i  = 1'b1;
        mem_data_i = rd;
        @(negedge clk);
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
    endtask

    task automatic drive(input logic req, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        cpu_req_i   = req;
        cpu_write_i = wr;
        cpu_addr_i  = addr;
        cpu_data_i  = data;
        #1;
    endtask

    logic [255:0] la, lb, lc, la_m;

    initial begin
        la = mkline(32'hA000_0000);
        lb = mkline(32'hB000_0000);
        lc = mkline(32'hC000_0000);
        la_m = la;
        la_m[63:32] = 32'hDEAD_BEEF;

        rst_i = 1'b1; model_clr = 1'b1;
        cpu_req_i = 1'b0; cpu_write_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
        mem_ack_i = 1'b0; mem_data_i = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset stall", cpu_stall_o, 1'b0);
        chk("reset sram_enable", sram_enable_o, 1'b0);
        chk("reset sram_write", sram_write_o, 1'b0);
        chk("reset mem_enable", mem_enable_o, 1'b0);
        chk("reset mem_write", mem_write_o, 1'b0);
        chk("reset mem_addr", mem_addr_o, 32'h0);
        chk("reset mem_data", mem_data_o, 256'h0);
        chk("reset cpu_data", cpu_data_o, 32'h0);
        @(negedge clk);
        rst_i = 1'b0; model_clr = 1'b0;

        // Cold load miss on set 2, way 0
        drive(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        chk("cold stall", cpu_stall_o, 1'b1);
        chk("cold way", sram_way_o, 1'b0);
        chk("cold set", sram_addr_o, 4'd2);
        mem_serve("cold fetch", 1'b0, 32'h0000_0040, 256'h0, la, 2);
        #1;
        chk("cold refill write", sram_write_o, 1'b1);
        chk("cold refill way", sram_way_o, 1'b0);
        chk("cold refill tag", sram_tag_o, 25'h100_0000);
        chk("cold refill data", sram_data_o, la);
        chk("cold refill mem_enable", mem_enable_o, 1'b0);
        chk("cold refill stall", cpu_stall_o, 1'b1);
        @(negedge clk);
        #1;
        chk("cold relookup stall", cpu_stall_o, 1'b0);
        chk("cold relookup data", cpu_data_o, 32'hA000_0000);

        // Load hit same line
        drive(1'b1, 1'b0, 32'h0000_0048, 32'h0);
        chk("hit stall", cpu_stall_o, 1'b0);
        chk("hit data", cpu_data_o, 32'hA000_0002);
        chk("hit no mem", mem_enable_o, 1'b0);
        chk("hit no write", sram_write_o, 1'b0);

        // Store hit merges word 1 and sets dirty
        drive(1'b1, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF);
        chk("store stall", cpu_stall_o, 1'b0);
        chk("store write", sram_write_o, 1'b1);
        chk("store way", sram_way_o, 1'b0);
        chk("store tag", sram_tag_o, 25'h180_0000);
        chk("store data", sram_data_o, la_m);
        drive(1'b1, 1'b0, 32'h0000_0044, 32'h0);
        chk("store readback", cpu_data_o, 32'hDEAD_BEEF);

        // Second tag in set 2 goes to way 1 (LRU names way 1 after way-0 hits)
        drive(1'b1, 1'b0, 32'h0000_0240, 32'h0);
        chk("way1 miss way", sram_way_o, 1'b1);
        mem_serve("way1 fetch", 1'b0, 32'h0000_0240, 256'h0, lb, 1);
        #1;
        chk("way1 refill way", sram_way_o, 1'b1);
        @(negedge clk);
        #1;
        chk("way1 relookup data", cpu_data_o, 32'hB000_0000);
`ifdef DCACHE_STATS_EN
        chk("stat hits", stat_hit_o, 32'd3);
        chk("stat misses", stat_miss_o, 32'd2);
`endif

        // Third tag evicts dirty way 0
        drive(1'b1, 1'b0, 32'h0000_0440, 32'h0);
        chk("evict way", sram_way_o, 1'b0);
        chk("evict stall", cpu_stall_o, 1'b1);
        mem_serve("evict wb", 1'b1, 32'h0000_0040, la_m, 256'h0, 1);
        mem_serve("evict fetch", 1'b0, 32'h0000_0440, 256'h0, lc, 0);
        #1;
        chk("evict refill way", sram_way_o, 1'b0);
        chk("evict refill tag", sram_tag_o, 25'h100_0002);
        chk("evict refill data", sram_data_o, lc);
        @(negedge clk);
        #1;
        chk("evict relookup data", cpu_data_o, 32'hC000_0000);

        // Stray ack while idle is ignored
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        mem_ack_i = 1'b1;
        @(negedge clk);
        mem_ack_i = 1'b0;
        #1;
        chk("stray ack mem_enable", mem_enable_o, 1'b0);
        chk("stray ack stall", cpu_stall_o, 1'b0);
        drive(1'b1, 1'b0, 32'h0000_0444, 32'h0);
        chk("post stray hit stall", cpu_stall_o, 1'b0);
        chk("post stray hit data", cpu_data_o, 32'hC000_0001);

        // Reset while FETCH is pending with ack
        drive(1'b1, 1'b0, 32'h0000_0640, 32'h0);
        chk("rst miss way", sram_way_o, 1'b1);
        @(negedge clk);
        #1;
        chk("rst fetch addr", mem_addr_o, 32'h0000_0640);
        rst_i = 1'b1; model_clr = 1'b1; mem_ack_i = 1'b1; mem_data_i = lb;
        #1;
        chk("rst mem_enable drop", mem_enable_o, 1'b0);
        chk("rst mem_addr", mem_addr_o, 32'h0);
        chk("rst sram_write", sram_write_o, 1'b0);
        @(negedge clk);
        cpu_req_i = 1'b0; mem_ack_i = 1'b0; mem_data_i = '0;
        @(negedge clk);
        rst_i = 1'b0; model_clr = 1'b0;
`ifdef DCACHE_STATS_EN
        #1;
        chk("rst stat hits", stat_hit_o, 32'd0);
        chk("rst stat misses", stat_miss_o, 32'd0);
`endif
        drive(1'b1, 1'b0, 32'h0000_0240, 32'h0);
        chk("post rst lru way", sram_way_o, 1'b0);
        chk("post rst stall", cpu_stall_o, 1'b1);
        mem_serve("post rst fetch", 1'b0, 32'h0000_0240, 256'h0, lb, 0);
        #1;
        chk("post rst refill way", sram_way_o, 1'b0);
        @(negedge clk);
        #1;
        chk("post rst relookup data", cpu_data_o, 32'hB000_0000);
        cpu_req_i = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
